prim_secded_inv_28_22_enc_pipe: RTL and testbench
=================================================

Name: prim_secded_inv_28_22_enc_pipe

Overview:
Registered write-path encoder for the inverted Hsiao SECDED(28,22) code. It produces codewords that the existing inverted 28/22 decoder accepts with a zero syndrome.
- 22-bit data in, 28-bit codeword out, over valid/ready streams.
- Output is fully registered, with a skid buffer so in_ready_o has no combinational path from out_ready_i.
- Per-beat bit-flip injection lets verification exercise the downstream decoder's single- and double-error paths.
- Sits between bus write-data and ECC-protected RAM / FIFO storage.

Parameters:
- EnableInject, 1, when 0 the inj_i port is ignored and tied off internally.
- CntW, 16, width of the accepted-beat counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  encoder can accept a beat
- in_data_i  in  22  payload
- inj_i  in  28  XOR flip mask applied to this beat's codeword
- out_valid_o  out  1  codeword valid
- out_ready_i  in  1  sink accepts codeword
- out_data_o  out  28  codeword; [21:0] payload, [27:22] check bits
- beat_cnt_o  out  CntW  count of accepted input beats, wraps
- idle_o  out  1  no beat held in output or skid register

Clock and reset interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, in_ready_o=1 (skid empty), beat_cnt_o=0, idle_o=1. All registers clear asynchronously on rst_ni low.
- Encoding, with raw_k = ^(d & M_k) for k=0..5:
  - M0=22'h3003FF, M1=22'h10FC0F, M2=22'h271C71, M3=22'h3B6592, M4=22'h3DAAA4, M5=22'h3ED348.
  - Check bits: c = raw ^ INV, where INV=6'h2A.
  - Codeword: {c, d} ^ (EnableInject ? inj_i : 0).
- Handshake:
  - Input beat accepted when in_valid_i && in_ready_o.
  - Output beat transfers when out_valid_o && out_ready_i.
  - in_valid_i may deassert at any time; no X-propagation requirement on data when valid is low.
- Storage: output register (OR) plus skid register (SK), with valid bits or_v and sk_v. in_ready_o = !sk_v, registered.
- Per-cycle cases:
  - Accept, OR empty or transferring, SK empty: the encoded beat loads OR next cycle.
  - Accept while OR is stalled (or_v && !out_ready_i): the beat loads SK; in_ready_o drops next cycle.
  - SK full and OR transfers: SK moves to OR, sk_v clears, in_ready_o rises next cycle.
  - Accept and transfer in the same cycle: OR is replaced by the new beat with no bubble.
- Timing and ordering:
  - Latency is 1 cycle input-accept to out_valid_o.
  - Full throughput of 1 beat/cycle while out_ready_i=1.
  - Order is strictly preserved.
- Stability: while out_valid_o && !out_ready_i, out_data_o and out_valid_o hold stable.
- inj_i is sampled with the accepted beat and stored already applied. Later changes to inj_i never alter a held codeword.
- beat_cnt_o increments on each accepted beat and wraps from 2^CntW-1 to 0.
- idle_o = !or_v && !sk_v.
- Reset mid-stream: held beats are discarded, with no output on the reset release cycle.
- Assertions:
  - out_data_o stable while stalled.
  - sk_v implies or_v.
  - With inj_i=0, the decoder syndrome of out_data_o is 0.

Decomposition:
- Package prim_secded_inv_28_22_pkg: the six 22-bit masks M0..M5, INV=6'h2A, width constants (K=22, N=28, R=6), and a codeword struct {check[5:0], data[21:0]}.
- Sub-module prim_secded_inv_28_22_enc: combinational d -> 28-bit codeword. The pipe instantiates it once at the input side, so both OR and SK store encoded words.

Test Plan:
1. Reset, then beat d=22'h000000, inj=0, out_ready=1 -> next cycle out_valid=1, out_data=28'hA800000; beat_cnt=1.
2. d=22'h3FFFFF -> out_data=28'hB3FFFFF; d=22'h000001 -> 28'hB400001. Feed both through the decoder model -> syndrome 0, err_o=0.
3. out_ready=0 with 2 beats sent (0x000001 then 0x3FFFFF) -> in_ready drops after the 2nd accept, out_data holds 28'hB400001. Then raise out_ready -> 28'hB400001 followed by 28'hB3FFFFF on consecutive cycles, then idle_o=1.
4. inj=28'h0000001 on d=0 -> out_data=28'hA800001; decoder reports err_o=2'b01 and corrects data to 0. inj=28'h0000003 -> err_o=2'b10.
5. Random valid/ready back-pressure, 10k beats -> scoreboard order/data match, no drops or duplicates, beat_cnt wraps correctly with CntW=4.
6. Assert rst_ni low with OR and SK full -> out_valid=0 and in_ready=1 immediately; after release, nothing is emitted until a new beat is accepted.

Source files
------------

// File: rtl/prim_secded_inv_28_22_pkg.sv
// Constants, codeword layout and helper functions for the inverted
// Hsiao SECDED(28,22) code shared by the encoder and the write pipe.
package prim_secded_inv_28_22_pkg;

  localparam int K = 22;  // payload bits
  localparam int N = 28;  // codeword bits
  localparam int R = 6;   // check bits

  // Parity masks: check bit k covers the payload bits set in M<k>.
  localparam logic [K-1:0] M0 = 22'h3003FF;
  localparam logic [K-1:0] M1 = 22'h10FC0F;
  localparam logic [K-1:0] M2 = 22'h271C71;
  localparam logic [K-1:0] M3 = 22'h3B6592;
  localparam logic [K-1:0] M4 = 22'h3DAAA4;
  localparam logic [K-1:0] M5 = 22'h3ED348;

  localparam logic [R-1:0][K-1:0] MASKS = {M5, M4, M3, M2, M1, M0};

  // Inversion pattern keeps the all-zero word from being a valid codeword.
  localparam logic [R-1:0] INV = 6'h2A;

  typedef struct packed {
    logic [R-1:0] check;
    logic [K-1:0] data;
  } cw_t;

  // Check bits for a payload, inversion already applied.
  function automatic logic [R-1:0] calc_check(input logic [K-1:0] d);
    logic [R-1:0] c;
    c = '0;
    for (int k = 0; k < R; k++) begin
      c[k] = ^(d & MASKS[k]);
    end
    return c ^ INV;
  endfunction

  // Decoder syndrome; zero for an undisturbed codeword.
  function automatic logic [R-1:0] calc_syndrome(input cw_t cw);
    return calc_check(cw.data) ^ cw.check;
  endfunction

endpackage

// File: rtl/prim_secded_inv_28_22_enc.sv
// Combinational inverted SECDED(28,22) encoder: payload -> codeword.
module prim_secded_inv_28_22_enc
  import prim_secded_inv_28_22_pkg::*;
(
  input  logic [K-1:0] data_i,
  output logic [N-1:0] cw_o
);

  cw_t cw;

  // Build the codeword with check bits above the untouched payload.
  always_comb begin
    cw.data  = data_i;
    cw.check = calc_check(data_i);
    cw_o     = cw;
  end

endmodule

// File: rtl/prim_secded_inv_28_22_enc_pipe.sv
// Registered write-path SECDED encoder with a one-entry skid buffer.
//
// Handshake: a beat moves across an interface only in a cycle where both
// valid and ready are high at the rising clock edge; a producer holding
// valid may not change its data until that happens. in_ready_o is driven
// straight from the skid-valid flop, so it never depends combinationally
// on out_ready_i.
module prim_secded_inv_28_22_enc_pipe
  import prim_secded_inv_28_22_pkg::*;
#(
  parameter bit EnableInject = 1'b1,
  parameter int CntW         = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [K-1:0]    in_data_i,
  input  logic [N-1:0]    inj_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N-1:0]    out_data_o,
  output logic [CntW-1:0] beat_cnt_o,
  output logic            idle_o
);

  logic [N-1:0] enc_cw;
  logic [N-1:0] inj_eff;
  logic [N-1:0] word;
  logic         word_clean;

  logic            or_v_q, or_v_d;
  logic [N-1:0]    or_q, or_d;
  logic            or_clean_q, or_clean_d;
  logic            sk_v_q, sk_v_d;
  logic [N-1:0]    sk_q, sk_d;
  logic            sk_clean_q, sk_clean_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic accept;
  logic or_free;

  prim_secded_inv_28_22_enc u_enc (
    .data_i (in_data_i),
    .cw_o   (enc_cw)
  );

  // Injection is folded in at the input so held words never see later inj_i.
  assign inj_eff    = EnableInject ? inj_i : '0;
  assign word       = enc_cw ^ inj_eff;
  assign word_clean = (inj_eff == '0);

  assign accept  = in_valid_i && !sk_v_q;
  assign or_free = !or_v_q || out_ready_i;

  // Next-state for output register, skid register and beat counter.
  always_comb begin
    or_v_d     = or_v_q;
    or_d       = or_q;
    or_clean_d = or_clean_q;
    sk_v_d     = sk_v_q;
    sk_d       = sk_q;
    sk_clean_d = sk_clean_q;
    cnt_d      = cnt_q;

    if (accept) begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (or_free) begin
      if (sk_v_q) begin
        // Skid drains first; no accept is possible while it is full.
        or_v_d     = 1'b1;
        or_d       = sk_q;
        or_clean_d = sk_clean_q;
        sk_v_d     = 1'b0;
      end else if (accept) begin
        or_v_d     = 1'b1;
        or_d       = word;
        or_clean_d = word_clean;
      end else begin
        or_v_d     = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled: park the new beat in the skid register.
      sk_v_d     = 1'b1;
      sk_d       = word;
      sk_clean_d = word_clean;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      or_v_q     <= 1'b0;
      or_q       <= '0;
      or_clean_q <= 1'b0;
      sk_v_q     <= 1'b0;
      sk_q       <= '0;
      sk_clean_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      or_v_q     <= or_v_d;
      or_q       <= or_d;
      or_clean_q <= or_clean_d;
      sk_v_q     <= sk_v_d;
      sk_q       <= sk_d;
      sk_clean_q <= sk_clean_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready_o  = !sk_v_q;
  assign out_valid_o = or_v_q;
  assign out_data_o  = or_q;
  assign beat_cnt_o  = cnt_q;
  assign idle_o      = !or_v_q && !sk_v_q;

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));

  a_sk_implies_or : assert property (@(posedge clk_i) disable iff (!rst_ni)
    sk_v_q |-> or_v_q);

  a_clean_syndrome : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (or_v_q && or_clean_q) |-> (calc_syndrome(cw_t'(or_q)) == '0));

endmodule

// File: tb/tb_prim_secded_inv_28_22_enc_pipe.sv
// Bench for the SECDED(28,22) write pipe: directed cases plus random
// traffic under back-pressure, checked by a queue scoreboard.
module tb_prim_secded_inv_28_22_enc_pipe;

  localparam int CNTW = 4;
  localparam logic [21:0] TB_MASK [6] = '{22'h3003FF, 22'h10FC0F, 22'h271C71,
                                          22'h3B6592, 22'h3DAAA4, 22'h3ED348};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [21:0]     in_data = '0;
  logic [27:0]     inj = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [27:0]     out_data;
  logic [CNTW-1:0] beat_cnt;
  logic            idle;

  prim_secded_inv_28_22_enc_pipe #(
    .EnableInject (1'b1),
    .CntW         (CNTW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .inj_i       (inj),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .beat_cnt_o  (beat_cnt),
    .idle_o      (idle)
  );

  // ---------------- reference model ----------------
  function automatic logic [5:0] ref_check(input logic [21:0] d);
    logic [5:0] c;
    for (int k = 0; k < 6; k++) begin
      int ones;
      ones = 0;
      for (int j = 0; j < 22; j++) begin
        if (TB_MASK[k][j] && d[j]) ones++;
      end
      c[k] = (ones % 2) == 1;
    end
    return c ^ 6'h2A;
  endfunction

  function automatic logic [27:0] ref_enc(input logic [21:0] d);
    return {ref_check(d), d};
  endfunction

  function automatic logic [5:0] ref_syn(input logic [27:0] cw);
    return ref_check(cw[21:0]) ^ cw[27:22];
  endfunction

  function automatic logic [1:0] ref_err(input logic [27:0] cw);
    logic [5:0] s;
    s = ref_syn(cw);
    if (s == 6'd0) return 2'b00;
    return ($countones(s) % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [21:0] ref_fix(input logic [27:0] cw);
    logic [21:0] d;
    logic [5:0]  s;
    logic [5:0]  col;
    d = cw[21:0];
    s = ref_syn(cw);
    if (ref_err(cw) == 2'b01) begin
      for (int j = 0; j < 22; j++) begin
        for (int k = 0; k < 6; k++) col[k] = TB_MASK[k][j];
        if (col == s) d[j] = ~d[j];
      end
    end
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [27:0] exp_q[$];
  logic [27:0] inj_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  int          cyc = 0;
  int          held = 0;
  int          tb_cnt = 0;
  int          n_out = 0;
  int          last_xfer_cyc = 0;
  int          prev_xfer_cyc = 0;
  bit          stalled_prev = 1'b0;
  logic [27:0] prev_data = '0;
  logic [27:0] last_out = '0;
  logic [27:0] exp_w;
  logic [27:0] exp_inj;

  always @(posedge clk) cyc++;

  // Monitor: occupancy, counter, stall stability, and output ordering.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("beat_cnt", 32'(beat_cnt), 32'(tb_cnt % (1 << CNTW)));
      chk("out_valid", 32'(out_valid), 32'(held > 0));
      chk("in_ready", 32'(in_ready), 32'(held < 2));
      chk("idle", 32'(idle), 32'(held == 0));
      if (stalled_prev) chk("stall_hold", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_w   = exp_q.pop_front();
          exp_inj = inj_q.pop_front();
          chk("out_data", 32'(out_data), 32'(exp_w));
          if (exp_inj == '0) chk("syndrome", 32'(ref_syn(out_data)), 32'd0);
        end
        last_out      = out_data;
        prev_xfer_cyc = last_xfer_cyc;
        last_xfer_cyc = cyc;
        n_out++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      held   = held + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      tb_cnt = tb_cnt + int'(in_valid && in_ready);
    end
  end

  // ---------------- sink ready driver ----------------
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready_mode(input int m);
    rdy_mode = m;
    step();
    step();
  endtask

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [21:0] d, input logic [27:0] m, input logic [27:0] e);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    inj      = m;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        inj_q.push_back(m);
        break;
      end
      waited++;
      if (waited >= 1000) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inj      = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || held != 0) && t < 2000) begin
      step();
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  logic [21:0] rd;
  logic [27:0] rinj;
  int          n0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();

    // Zero payload and single-beat latency.
    send(22'h000000, 28'h0, 28'hA800000);
    chk("t1_valid_next", 32'(out_valid), 32'd1);
    chk("t1_data_next", 32'(out_data), 32'hA800000);
    wait_drain();
    chk("t1_cnt", 32'(beat_cnt), 32'd1);

    // All-ones and single-bit payloads.
    send(22'h3FFFFF, 28'h0, 28'hB3FFFFF);
    send(22'h000001, 28'h0, 28'hB400001);
    wait_drain();

    // Stall with both registers full, then release.
    set_ready_mode(0);
    send(22'h000001, 28'h0, 28'hB400001);
    chk("t3_ready_after_1", 32'(in_ready), 32'd1);
    send(22'h3FFFFF, 28'h0, 28'hB3FFFFF);
    chk("t3_ready_dropped", 32'(in_ready), 32'd0);
    chk("t3_hold_data", 32'(out_data), 32'hB400001);
    step();
    step();
    chk("t3_hold_data_later", 32'(out_data), 32'hB400001);
    set_ready_mode(1);
    wait_drain();
    chk("t3_back_to_back", 32'(last_xfer_cyc - prev_xfer_cyc), 32'd1);
    step();
    chk("t3_idle", 32'(idle), 32'd1);

    // Injected single and double errors seen by the decoder model.
    send(22'h000000, 28'h0000001, 28'hA800001);
    wait_drain();
    chk("t4_single_err", 32'(ref_err(last_out)), 32'd1);
    chk("t4_single_fix", 32'(ref_fix(last_out)), 32'd0);
    send(22'h000000, 28'h0000003, 28'hA800003);
    wait_drain();
    chk("t4_double_err", 32'(ref_err(last_out)), 32'd2);

    // Random traffic with random source gaps and sink back-pressure.
    set_ready_mode(2);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end
      rd   = 22'($urandom);
      rinj = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'h0;
      send(rd, rinj, ref_enc(rd) ^ rinj);
    end
    set_ready_mode(1);
    wait_drain();

    // Reset with output and skid registers both occupied.
    set_ready_mode(0);
    send(22'h0ABCDE, 28'h0, ref_enc(22'h0ABCDE));
    send(22'h123456, 28'h0, ref_enc(22'h123456));
    chk("t6_full_before_rst", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_idle", 32'(idle), 32'd1);
    chk("t6_rst_cnt", 32'(beat_cnt), 32'd0);
    exp_q.delete();
    inj_q.delete();
    held         = 0;
    tb_cnt       = 0;
    stalled_prev = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    set_ready_mode(1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_output", 32'(out_valid), 32'd0);
      step();
    end
    n0 = n_out;
    send(22'h2AAAAA, 28'h0, ref_enc(22'h2AAAAA));
    wait_drain();
    chk("t6_one_output", 32'(n_out - n0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
